// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the RV32I instruction fetch stage.
// FSM encoding, IF/ID bundle and the canonical NOP.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISCARD,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    valid: 1'b0,
    pc:    32'h0,
    instr: NOP_INSTR
  };

  // Instructions are word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: req/gnt/rvalid instruction-memory port.
// master = fetch side, slave = memory side.
interface fetch_unit_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Priority: flush, stall, load, bubble.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t load_data_i,
  output if_id_t if_id_o
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Next IF/ID contents; pc is kept on flush and bubble.
  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (load_i) begin
      if_id_d = load_data_i;
    end else begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end
  end

  // IF/ID state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_id_q <= IF_ID_RESET;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with one outstanding imem request.
// Owns fetch PC, drop-on-redirect FSM and a one-entry stall skid.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_src_optn_i,
  input  logic [31:0] target_addr_i,
  input  logic        flush_req_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o
);

  localparam if_id_t SKID_RESET = '{
    valid: 1'b0,
    pc:    32'h0,
    instr: NOP_INSTR
  };

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       skid_q, skid_d;
  logic         req_q, req_d;

  logic         redirect;
  logic         load;
  if_id_t       load_data;
  if_id_t       if_id;

  assign redirect = pc_src_optn_i;

  // Next-state, fetch PC and skid logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    load      = 1'b0;
    load_data = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i};
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect) begin
            state_d = S_REQ;
          end else if (!stall_i) begin
            load    = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end else begin
            skid_d  = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i};
            pc_d    = pc_q + 32'd4;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          skid_d.valid = 1'b0;
          state_d      = S_REQ;
        end else if (!stall_i) begin
          load         = 1'b1;
          load_data    = skid_q;
          skid_d.valid = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (redirect) begin
      pc_d = word_align(target_addr_i);
    end
    req_d = (state_d == S_REQ);
  end

  // Fetch FSM, PC, skid and registered request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      skid_q  <= SKID_RESET;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_req_i),
    .stall_i     (stall_i),
    .load_i      (load),
    .load_data_i (load_data),
    .if_id_o     (if_id)
  );

  assign if_id_valid_o    = if_id.valid;
  assign if_id_pc_o       = if_id.pc;
  assign if_id_pc_plus4_o = if_id.pc + 32'd4;
  assign if_id_instr_o    = if_id.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random imem latency, stalls, flushes, redirects.
// Fetch stream model feeds a scoreboard checked against IF/ID.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] target;
  logic        stall;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pc_src_optn_i    (pc_src),
    .target_addr_i    (target),
    .flush_req_i      (flush),
    .stall_i          (stall),
    .imem_req_o       (imem.req),
    .imem_addr_o      (imem.addr),
    .imem_gnt_i       (imem.gnt),
    .imem_rvalid_i    (imem.rvalid),
    .imem_rdata_i     (imem.rdata),
    .if_id_valid_o    (if_id_valid),
    .if_id_pc_o       (if_id_pc),
    .if_id_pc_plus4_o (if_id_pc4),
    .if_id_instr_o    (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int loads = 0;
  int wrap_seen = 0;
  int cyc = 0;
  logic first_done = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] exp_addr;
  logic        outst;
  logic [31:0] out_addr;
  int          rv_cnt;
  int          gnt_pct;
  int          rvx;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0010_0093;
    if (a == 32'h0000_000C) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Memory responder plus stimulus; expected fetches enqueued at grant.
  task automatic step(input logic red, input logic [31:0] tgt,
                      input logic st, input logic fl);
    exp_t n;
    @(negedge clk);
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom;
    if (imem.req) chk("one_outstanding", {31'd0, outst}, 32'd0);
    if (outst) begin
      if (rv_cnt == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem(out_addr);
        outst       = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (imem.req && $urandom_range(1, 100) <= gnt_pct) begin
      imem.gnt = 1'b1;
      chk("req_addr", imem.addr, exp_addr);
      outst    = 1'b1;
      out_addr = imem.addr;
      rv_cnt   = $urandom_range(0, rvx);
      if (!red) begin
        n.pc    = exp_addr;
        n.instr = mem(exp_addr);
        exp_q.push_back(n);
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (red) begin
      exp_q.delete();
      exp_addr = tgt & 32'hFFFF_FFFC;
    end
    pc_src = red;
    target = tgt;
    stall  = st;
    flush  = fl;
  endtask

  task automatic enter_reset();
    rst_n       = 1'b0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    pc_src      = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    outst       = 1'b0;
    exp_q.delete();
    exp_addr = RESET_PC;
    gnt_pct  = 100;
    rvx      = 0;
  endtask

  // Monitor: IF/ID model driven by the scoreboard queue.
  initial begin
    logic        s_rst, s_st, s_fl;
    logic        m_valid;
    logic [31:0] m_pc, m_instr;
    exp_t        e;
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_instr = NOP;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_st  = stall;
      s_fl  = flush;
      #1;
      if (!s_rst) begin
        cyc = 0;
        first_done = 1'b0;
        m_valid = 1'b0;
        chk("rst_req", {31'd0, imem.req}, 32'd0);
        chk("rst_addr", imem.addr, RESET_PC);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd4);
        chk("rst_instr", if_id_instr, NOP);
      end else begin
        cyc++;
        if (cyc == 1) begin
          chk("first_req", {31'd0, imem.req}, 32'd1);
          chk("first_addr", imem.addr, RESET_PC);
        end
        if (s_fl) begin
          m_valid = 1'b0;
        end else if (!s_st) begin
          if (if_id_valid) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL if_id_unexpected: got pc %h want none",
                       if_id_pc);
            end else begin
              e = exp_q.pop_front();
              m_valid = 1'b1;
              m_pc    = e.pc;
              m_instr = e.instr;
              loads++;
              if (e.pc == 32'hFFFF_FFFC) wrap_seen++;
              if (!first_done) begin
                first_done = 1'b1;
                chk("first_valid_cycle", cyc, 32'd3);
              end
            end
          end else begin
            m_valid = 1'b0;
          end
        end
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("if_id_instr", if_id_instr, m_valid ? m_instr : NOP);
        if (m_valid) begin
          chk("if_id_pc", if_id_pc, m_pc);
          chk("if_id_pc4", if_id_pc4, m_pc + 32'd4);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic        red, st, fl;
    logic [31:0] tgt;
    target      = 32'h0;
    imem.rdata  = 32'h0;
    enter_reset();
    repeat (3) @(negedge clk);
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD0_BAD0;
    rst_n       = 1'b1;

    // Zero-wait start, stall over the pc 12 response, flush with stall,
    // then a flushing redirect to the top word to cross the wrap.
    for (int k = 1; k <= 30; k++) begin
      step(k == 14, 32'hFFFF_FFFC, (k >= 8 && k <= 10), (k == 9 || k == 14));
    end

    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rvx     = $urandom_range(0, 3);
      end
      red = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hCAFE_BABE;
        1:       tgt = 32'h0000_2000;
        2:       tgt = 32'hFFFF_FFF4;
        default: tgt = $urandom;
      endcase
      st = ($urandom_range(0, 99) < 25);
      fl = red ? 1'($urandom_range(0, 1))
               : (st && ($urandom_range(0, 9) == 0));
      step(red, tgt, st, fl);
    end

    @(negedge clk);
    enter_reset();
    #1;
    chk("async_rst_req", {31'd0, imem.req}, 32'd0);
    chk("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("async_rst_instr", if_id_instr, NOP);
    repeat (2) @(negedge clk);
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0BAD_F00D;
    rst_n       = 1'b1;
    repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    chk("enough_loads", {31'd0, loads > 100}, 32'd1);
    chk("wrap_seen", {31'd0, wrap_seen > 0}, 32'd1);
    chk("post_reset_fetch", {31'd0, first_done}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
